stepper_move_ctrl: RTL and testbench

Move sequencer that drives the 32-bit command word of the stepper phase driver. It accepts a move request (step count, direction, cruise period) over a valid/ready handshake. It runs a trapezoidal (or triangular) acceleration profile by stepping the half-step period between a slow limit and the requested cruise period. It counts steps with its own period timer, which matches the driver's timing, and pulses done when the move completes or an abort finishes its ramp-down.

---
 rtl/stepper_move_ctrl.sv | 179 +++++++++++++++++
 tb/tb_stepper_move_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_ctrl.sv
`default_nettype none
// ==== stepper_move_ctrl : trapezoidal move sequencer driving the phase-driver command word ====
// ==== Revision 1.0                                                                          ====
module stepper_move_ctrl #(
  parameter int MIN_PERIOD  = 550000,
  parameter int MAX_PERIOD  = 2000000,
  parameter int ACCEL_DELTA = 50000,
  parameter int STEP_W      = 16
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [STEP_W-1:0] move_steps,
  input  logic              move_dir,
  input  logic [21:0]       move_period,
  input  logic              abort,
  output logic [31:0]       command,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [21:0] c_min   = 22'(MIN_PERIOD);
  localparam logic [21:0] c_max   = 22'(MAX_PERIOD);
  localparam logic [22:0] c_delta = 23'(ACCEL_DELTA);

  state_t            state_q, state_d;
  logic [21:0]       cur_q, cur_d, target_q, target_d, timer_q, timer_d;
  logic [STEP_W-1:0] rem_q, rem_d, ramp_q, ramp_d, steps_done_q, steps_done_d;
  logic              dir_q, dir_d, abort_pend_q, abort_pend_d;
  logic [31:0]       command_q, command_d;
  logic              busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic [21:0]       w_clamped, w_cur_down, w_cur_up;
  logic [22:0]       w_sum_up;
  logic [STEP_W-1:0] w_rem_dec, w_ramp_inc;
  logic              w_busy_now;

  always_comb begin
    w_clamped  = (move_period < c_min) ? c_min :
                 (move_period > c_max) ? c_max : move_period;
    // Period arithmetic is widened one bit so neither direction can wrap.
    w_cur_down = ({1'b0, cur_q} >= ({1'b0, target_q} + c_delta)) ?
                 (cur_q - c_delta[21:0]) : target_q;
    w_sum_up   = {1'b0, cur_q} + c_delta;
    w_cur_up   = (w_sum_up > {1'b0, c_max}) ? c_max : w_sum_up[21:0];
    w_rem_dec  = rem_q - STEP_W'(1);
    w_ramp_inc = ramp_q + STEP_W'(1);
    w_busy_now = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);

    state_d      = state_q;
    cur_d        = cur_q;
    target_d     = target_q;
    timer_d      = timer_q;
    rem_d        = rem_q;
    ramp_d       = ramp_q;
    steps_done_d = steps_done_q;
    dir_d        = dir_q;
    abort_pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (move_valid) begin
          dir_d        = move_dir;
          target_d     = w_clamped;
          rem_d        = move_steps;
          ramp_d       = '0;
          cur_d        = c_max;
          timer_d      = '0;
          steps_done_d = '0;
          if (move_steps == '0)      state_d = S_DONE;
          else if (w_clamped == c_max) state_d = S_CRUISE;
          else                       state_d = S_ACCEL;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        if (timer_q == cur_q) begin
          timer_d      = '0;
          steps_done_d = steps_done_q + STEP_W'(1);
          rem_d        = w_rem_dec;
          if (w_rem_dec == '0) begin
            state_d = S_DONE;
          end else begin
            case (state_q)
              S_ACCEL: begin
                ramp_d       = w_ramp_inc;
                abort_pend_d = abort;
                if (w_rem_dec <= w_ramp_inc) begin
                  state_d = S_DECEL;
                end else begin
                  cur_d = w_cur_down;
                  if (w_cur_down == target_q) state_d = S_CRUISE;
                end
              end
              S_CRUISE: begin
                abort_pend_d = abort;
                if (w_rem_dec <= ramp_q) state_d = S_DECEL;
              end
              default: begin
                cur_d  = w_cur_up;
                ramp_d = (ramp_q == '0) ? '0 : ramp_q - STEP_W'(1);
              end
            endcase
          end
        end else begin
          timer_d = timer_q + 22'd1;
          // A stop request ramps down over as many steps as were spent ramping up.
          if ((abort || abort_pend_q) && (state_q != S_DECEL)) begin
            if (ramp_q == '0) begin
              state_d = S_DONE;
            end else begin
              rem_d   = ramp_q;
              state_d = S_DECEL;
            end
          end
        end
      end
    endcase

    busy_d  = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    command_d = w_busy_now ? {7'b0, dir_q, 1'b1, 1'b1, cur_q}
                           : {7'b0, dir_q, 1'b0, 1'b0, c_max};
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= S_IDLE;
      cur_q        <= c_max;
      target_q     <= c_max;
      timer_q      <= '0;
      rem_q        <= '0;
      ramp_q       <= '0;
      steps_done_q <= '0;
      dir_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      command_q    <= {10'b0, c_max};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      rem_q        <= rem_d;
      ramp_q       <= ramp_d;
      steps_done_q <= steps_done_d;
      dir_q        <= dir_d;
      abort_pend_q <= abort_pend_d;
      command_q    <= command_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  assign move_ready = ready_q;
  assign command    = command_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_done = steps_done_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_move_ctrl.sv
`default_nettype none
// ==== tb_stepper_move_ctrl : directed and random moves against a step-level profile model ====
// ==== Revision 1.0                                                                         ====
module tb_stepper_move_ctrl;

  localparam int MINP  = 10;
  localparam int MAXP  = 40;
  localparam int DELTA = 10;
  localparam int SW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          move_valid = 1'b0;
  logic          move_ready;
  logic [SW-1:0] move_steps = '0;
  logic          move_dir = 1'b0;
  logic [21:0]   move_period = '0;
  logic          abort = 1'b0;
  logic [31:0]   command;
  logic          busy, done;
  logic [SW-1:0] steps_done;

  stepper_move_ctrl #(
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .ACCEL_DELTA(DELTA), .STEP_W(SW)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_steps(move_steps), .move_dir(move_dir), .move_period(move_period),
    .abort(abort), .command(command), .busy(busy), .done(done),
    .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Expected move, expressed as edge times counted from the accepting edge (edge 0).
  int step_edge[$];
  int seg_start[$];
  int seg_cur[$];
  int done_edge;

  task automatic model_move(input int steps, input int period, input int abort_edge);
    int cur, tgt, rem, ramp, phase, last, ns, ab;
    step_edge.delete(); seg_start.delete(); seg_cur.delete();
    tgt  = (period < MINP) ? MINP : ((period > MAXP) ? MAXP : period);
    cur  = MAXP; rem = steps; ramp = 0; last = 0; ab = abort_edge;
    seg_start.push_back(0); seg_cur.push_back(cur);
    if (steps == 0) begin done_edge = 0; return; end
    phase = (tgt == MAXP) ? 1 : 0;   // 0 accel, 1 cruise, 2 decel
    forever begin
      ns = last + cur + 1;
      if (ab >= 0 && ab < ns) begin
        if (phase != 2) begin
          if (ramp == 0) begin done_edge = ab; return; end
          rem = ramp; phase = 2;
        end
        ab = -1;
      end
      if (ab == ns) ab = ns + 1;
      step_edge.push_back(ns);
      last = ns;
      rem--;
      if (rem == 0) begin done_edge = ns; return; end
      case (phase)
        0: begin
          ramp++;
          if (rem <= ramp) phase = 2;
          else begin
            cur = (cur - DELTA > tgt) ? cur - DELTA : tgt;
            if (cur == tgt) phase = 1;
          end
        end
        1: if (rem <= ramp) phase = 2;
        default: begin
          cur = (cur + DELTA > MAXP) ? MAXP : cur + DELTA;
          if (ramp > 0) ramp--;
        end
      endcase
      seg_start.push_back(ns); seg_cur.push_back(cur);
    end
  endtask

  function automatic int cur_at(input int m);
    int c = MAXP;
    foreach (seg_start[j]) if (seg_start[j] <= m) c = seg_cur[j];
    return c;
  endfunction

  task automatic run_move(input int steps, input int period, input logic dir, input int abort_edge);
    int cnt, m;
    logic [31:0] exp_cmd;
    model_move(steps, period, abort_edge);
    @(negedge clk);
    check_eq("ready_before_accept", 32'(move_ready), 32'd1);
    move_valid  = 1'b1;
    move_steps  = SW'(steps);
    move_period = 22'(period);
    move_dir    = dir;
    @(posedge clk);
    for (int n = 0; n <= done_edge + 1; n++) begin
      @(negedge clk);
      if (n == 0) move_valid = 1'b0;
      abort = (n + 1 == abort_edge);
      cnt = 0;
      foreach (step_edge[k]) if (step_edge[k] <= n) cnt++;
      check_eq("steps_done", 32'(steps_done), 32'(cnt));
      check_eq("busy",  32'(busy),  32'(n < done_edge));
      check_eq("done",  32'(done),  32'(n == done_edge));
      check_eq("ready", 32'(move_ready), 32'(n > done_edge));
      if (n >= 1) begin
        m = n - 1;
        exp_cmd = (m < done_edge) ? {7'b0, dir, 2'b11, 22'(cur_at(m))}
                                  : {7'b0, dir, 2'b00, 22'(MAXP)};
        check_eq("command", command, exp_cmd);
      end
    end
    abort = 1'b0;
    check_eq("final_steps", 32'(steps_done), 32'(step_edge.size()));
  endtask

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, pr, ab;
    logic dr;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(move_ready), 32'd1);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_steps", 32'(steps_done), 32'd0);
    check_eq("rst_cmd",   command, {10'b0, 22'(MAXP)});
    rst_n = 1'b1;
    @(negedge clk);

    run_move(0,   10, 1'b0, -1);
    run_move(4,   10, 1'b1, -1);
    run_move(10,  10, 1'b0, -1);
    run_move(10,  10, 1'b1, -1);
    run_move(3,    5, 1'b0, -1);
    run_move(3,  100, 1'b1, -1);
    run_move(10,  10, 1'b0, 117);   // abort just after step 5, in cruise
    run_move(10,  10, 1'b1, 93);    // abort on the step that reaches cruise
    run_move(10,  10, 1'b0, 41);    // abort on the very first step
    run_move(10,  10, 1'b1, 5);     // abort before any step

    for (int i = 0; i < 25; i++) begin
      st = $urandom_range(0, 12);
      pr = $urandom_range(0, 60);
      dr = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, st * 41 + 5) : -1;
      run_move(st, pr, dr, ab);
    end

    // Asynchronous reset in the middle of a cruise move.
    @(negedge clk);
    move_valid = 1'b1; move_steps = SW'(10); move_period = 22'd100; move_dir = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("cruise_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ready", 32'(move_ready), 32'd1);
    check_eq("arst_busy",  32'(busy), 32'd0);
    check_eq("arst_done",  32'(done), 32'd0);
    check_eq("arst_steps", 32'(steps_done), 32'd0);
    check_eq("arst_cmd",   command, {10'b0, 22'(MAXP)});
    repeat (2) @(negedge clk);
    check_eq("arst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_rst_done",  32'(done), 32'd0);
      check_eq("post_rst_ready", 32'(move_ready), 32'd1);
      check_eq("post_rst_cmd",   command, {10'b0, 22'(MAXP)});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
